// File: rtl/if_fetch_stage.sv
// Instruction fetch front end.
//
// Issues in-order fetch requests over a req/gnt + rvalid memory interface, buffers the
// returned words in a small prefetch queue and drives the IF/ID pipeline register.
// Sequential fetch advances by 4. A taken branch redirects fetch and flushes the queue and
// IF/ID. Responses still in flight at the time of the branch are dropped as they arrive.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   freeze                    hazard stall: hold IF/ID, do not pop the queue
//   branch_taken, branch_addr redirect pulse and word-aligned target
//   imem_req, imem_addr       fetch request and address
//   imem_gnt                  request accepted this cycle
//   imem_rvalid, imem_rdata   read response, returned in grant order
//   Instruction, PC, inst_valid  IF/ID register (PC is the instruction address + 4)
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic        inst_valid
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW:0] DepthSum = FIFO_DEPTH[CntW:0];

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] discard_q, discard_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [31:0]     q_inst_q [FIFO_DEPTH];
  logic [31:0]     q_pc_q   [FIFO_DEPTH];
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     pc_q, pc_d;
  logic            valid_q, valid_d;

  logic            req;
  logic            grant;
  logic            push;
  logic            pop;
  logic [CntW:0]   occupancy;

  // Credit rule: every outstanding request owns a queue slot, so a push never overflows.
  assign occupancy = {1'b0, inflight_q} + {1'b0, count_q};
  assign req       = rst && !branch_taken && (occupancy < DepthSum);
  assign grant     = req && imem_gnt;

  assign imem_req    = req;
  assign imem_addr   = fetch_pc_q;
  assign Instruction = instr_q;
  assign PC          = pc_q;
  assign inst_valid  = valid_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    count_d    = count_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (branch_taken) begin
      fetch_pc_d = branch_addr;
      resp_pc_d  = branch_addr;
      count_d    = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      // The word returning in this cycle is dropped outright; the rest are skipped later.
      inflight_d = inflight_q - CntW'(imem_rvalid);
      discard_d  = inflight_q - CntW'(imem_rvalid);
      instr_d    = '0;
      pc_d       = '0;
      valid_d    = 1'b0;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      inflight_d = inflight_q + CntW'(grant) - CntW'(imem_rvalid);

      if (imem_rvalid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - 1'b1;
        end else begin
          push      = 1'b1;
          resp_pc_d = resp_pc_q + 32'd4;
        end
      end

      if (!freeze) begin
        if (count_q != '0) begin
          pop     = 1'b1;
          instr_d = q_inst_q[rptr_q];
          pc_d    = q_pc_q[rptr_q];
          valid_d = 1'b1;
        end else begin
          instr_d = '0;
          pc_d    = '0;
          valid_d = 1'b0;
        end
      end

      if (push) begin
        wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      instr_q    <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  // Queue storage needs no reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst_q[wptr_q] <= imem_rdata;
      q_pc_q[wptr_q]   <= resp_pc_q + 32'd4;
    end
  end

  // A response with nothing outstanding is a memory protocol violation.
  assert property (@(posedge clk) disable iff (!rst) imem_rvalid |-> (inflight_q != '0))
    else $error("imem_rvalid with no request in flight");

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic        inst_valid;

  int checks = 0;
  int errors = 0;

  // Memory model state: pending responses in grant order, each due in a given cycle.
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          lat = 1;

  if_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .Instruction (Instruction),
    .PC          (PC),
    .inst_valid  (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hE080_0001;
    if (a == 32'h4) return 32'hE081_1002;
    return 32'hC000_0000 | a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample the handshake before the edge, then update the memory model.
  task automatic tick();
    logic        g;
    logic [31:0] a;
    #1;
    g = rst && imem_req && imem_gnt;
    a = imem_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (g) begin
      pend_addr.push_back(a);
      pend_due.push_back(cyc + lat - 1);
    end
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr[0]);
      pend_addr.delete(0);
      pend_due.delete(0);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
  endtask

  task automatic do_reset(input int latency);
    rst          = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    imem_gnt     = 1'b1;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    lat          = latency;
    pend_addr.delete();
    pend_due.delete();
    repeat (3) tick();
    chk("reset_req_low", {31'h0, imem_req}, 32'h0);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    // Reset and straight-line fetch, 1-cycle memory.
    do_reset(1);
    chk("rst_req", {31'h0, imem_req}, 32'h1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_pc", PC, 32'h0);
    tick();  // C1
    chk("sl_c1_req", {31'h0, imem_req}, 32'h1);
    chk("sl_c1_addr", imem_addr, 32'h4);
    tick();  // C2: two credits used
    chk("sl_c2_req", {31'h0, imem_req}, 32'h0);
    chk("sl_c2_valid", {31'h0, inst_valid}, 32'h0);
    tick();  // C3
    chk("sl_c3_valid", {31'h0, inst_valid}, 32'h1);
    chk("sl_c3_instr", Instruction, 32'hE080_0001);
    chk("sl_c3_pc", PC, 32'h4);
    chk("sl_c3_addr", imem_addr, 32'h8);
    tick();  // C4
    chk("sl_c4_instr", Instruction, 32'hE081_1002);
    chk("sl_c4_pc", PC, 32'h8);
    tick();
    tick();  // C6
    chk("sl_c6_instr", Instruction, 32'hC000_0008);
    chk("sl_c6_pc", PC, 32'hC);

    // Freeze over C3..C5 with the queue filling up.
    do_reset(1);
    repeat (3) tick();  // C3
    chk("fz_c3_instr", Instruction, 32'hE080_0001);
    freeze = 1'b1;
    tick();
    tick();  // C5: queue full
    chk("fz_c5_req", {31'h0, imem_req}, 32'h0);
    chk("fz_c5_instr", Instruction, 32'hE080_0001);
    chk("fz_c5_pc", PC, 32'h4);
    tick();  // C6
    chk("fz_c6_req", {31'h0, imem_req}, 32'h0);
    chk("fz_c6_valid", {31'h0, inst_valid}, 32'h1);
    chk("fz_c6_pc", PC, 32'h4);
    freeze = 1'b0;
    tick();  // C7
    chk("fz_c7_instr", Instruction, 32'hE081_1002);
    chk("fz_c7_pc", PC, 32'h8);
    chk("fz_c7_req", {31'h0, imem_req}, 32'h1);
    chk("fz_c7_addr", imem_addr, 32'hC);
    tick();  // C8
    chk("fz_c8_instr", Instruction, 32'hC000_0008);
    chk("fz_c8_pc", PC, 32'hC);

    // Branch with two responses in flight, 3-cycle memory.
    do_reset(3);
    tick();  // C1
    chk("br_c1_addr", imem_addr, 32'h4);
    tick();  // C2
    chk("br_c2_req", {31'h0, imem_req}, 32'h0);
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    tick();  // C3
    branch_taken = 1'b0;
    chk("br_c3_addr", imem_addr, 32'h100);
    chk("br_c3_valid", {31'h0, inst_valid}, 32'h0);
    tick();  // C4
    chk("br_c4_req", {31'h0, imem_req}, 32'h1);
    chk("br_c4_addr", imem_addr, 32'h100);
    tick();  // C5
    chk("br_c5_addr", imem_addr, 32'h104);
    for (int i = 5; i <= 8; i++) begin
      chk($sformatf("br_c%0d_valid", i), {31'h0, inst_valid}, 32'h0);
      tick();
    end
    // C9
    chk("br_c9_valid", {31'h0, inst_valid}, 32'h1);
    chk("br_c9_instr", Instruction, 32'hC000_0100);
    chk("br_c9_pc", PC, 32'h104);
    tick();  // C10
    chk("br_c10_instr", Instruction, 32'hC000_0104);
    chk("br_c10_pc", PC, 32'h108);

    // Grant stall at address 8 for C3..C6.
    do_reset(1);
    repeat (3) tick();  // C3
    chk("gs_c3_addr", imem_addr, 32'h8);
    imem_gnt = 1'b0;
    for (int i = 4; i <= 6; i++) begin
      tick();
      chk($sformatf("gs_c%0d_req", i), {31'h0, imem_req}, 32'h1);
      chk($sformatf("gs_c%0d_addr", i), imem_addr, 32'h8);
    end
    chk("gs_c6_valid", {31'h0, inst_valid}, 32'h0);
    tick();  // C7
    chk("gs_c7_addr", imem_addr, 32'h8);
    imem_gnt = 1'b1;
    tick();  // C8
    chk("gs_c8_addr", imem_addr, 32'hC);
    tick();
    tick();  // C10
    chk("gs_c10_instr", Instruction, 32'hC000_0008);
    chk("gs_c10_pc", PC, 32'hC);

    // Branch, freeze and rvalid together in C4.
    do_reset(1);
    repeat (4) tick();  // C4
    chk("bf_c4_pc", PC, 32'h8);
    chk("bf_c4_rvalid", {31'h0, imem_rvalid}, 32'h1);
    branch_taken = 1'b1;
    branch_addr  = 32'h40;
    freeze       = 1'b1;
    #1;
    chk("bf_c4_req", {31'h0, imem_req}, 32'h0);
    tick();  // C5
    branch_taken = 1'b0;
    freeze       = 1'b0;
    chk("bf_c5_valid", {31'h0, inst_valid}, 32'h0);
    chk("bf_c5_instr", Instruction, 32'h0);
    chk("bf_c5_pc", PC, 32'h0);
    chk("bf_c5_addr", imem_addr, 32'h40);
    tick();  // C6
    chk("bf_c6_valid", {31'h0, inst_valid}, 32'h0);
    tick();  // C7
    chk("bf_c7_valid", {31'h0, inst_valid}, 32'h0);
    tick();  // C8
    chk("bf_c8_valid", {31'h0, inst_valid}, 32'h1);
    chk("bf_c8_instr", Instruction, 32'hC000_0040);
    chk("bf_c8_pc", PC, 32'h44);
    tick();  // C9
    chk("bf_c9_instr", Instruction, 32'hC000_0044);
    chk("bf_c9_pc", PC, 32'h48);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
